// File: rtl/traffic_light_ctrl.sv
// Phase sequencer for a two-road intersection with a pedestrian walk phase.
// Phase lengths are counted in prescaler ticks; lamps decode from state only.
module traffic_light_ctrl #(
    parameter int TIMER_WIDTH  = 4,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 2,
    parameter int ALLRED_TICKS = 1,
    parameter int PED_TICKS    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic                   ew_car,
    input  logic                   ped_req,
    output logic [2:0]             ns_lamp,
    output logic [2:0]             ew_lamp,
    output logic                   walk,
    output logic [2:0]             state,
    output logic [TIMER_WIDTH-1:0] timer,
    output logic                   phase_done
);

    localparam logic [2:0] S_NS_G = 3'd0;
    localparam logic [2:0] S_NS_Y = 3'd1;
    localparam logic [2:0] S_AR1  = 3'd2;
    localparam logic [2:0] S_EW_G = 3'd3;
    localparam logic [2:0] S_EW_Y = 3'd4;
    localparam logic [2:0] S_AR2  = 3'd5;
    localparam logic [2:0] S_PED  = 3'd6;

    localparam logic [TIMER_WIDTH-1:0] LD_GREEN =
        TIMER_WIDTH'(GREEN_TICKS - 1);
    localparam logic [TIMER_WIDTH-1:0] LD_YELLOW =
        TIMER_WIDTH'(YELLOW_TICKS - 1);
    localparam logic [TIMER_WIDTH-1:0] LD_ALLRED =
        TIMER_WIDTH'(ALLRED_TICKS - 1);
    localparam logic [TIMER_WIDTH-1:0] LD_PED =
        TIMER_WIDTH'(PED_TICKS - 1);

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;

    logic [2:0]             r_state;
    logic [TIMER_WIDTH-1:0] r_timer;
    logic                   r_ped;
    logic                   r_ret_ew;
    logic                   r_phase_done;

    logic [2:0]             w_next;
    logic [TIMER_WIDTH-1:0] w_timer_nxt;
    logic                   w_expired;
    logic                   w_adv;
    logic                   w_enter_ped;
    logic                   w_ped_nxt;
    logic                   w_ret_nxt;
    logic [TIMER_WIDTH-1:0] w_load;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_AR2;
            r_timer      <= LD_ALLRED;
            r_ped        <= 1'b0;
            r_ret_ew     <= 1'b0;
            r_phase_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_timer      <= w_timer_nxt;
            r_ped        <= w_ped_nxt;
            r_ret_ew     <= w_ret_nxt;
            r_phase_done <= w_adv;
        end
    end

    always_comb begin
        // code 7 behaves as an expired ALL_RED_2
        w_expired = (r_state == 3'd7) || (r_timer == '0);
        w_next    = r_state;
        if (tick && w_expired) begin
            unique case (r_state)
                S_NS_G:  if (ew_car || r_ped) w_next = S_NS_Y;
                S_NS_Y:  w_next = S_AR1;
                S_AR1:   w_next = r_ped ? S_PED : S_EW_G;
                S_EW_G:  w_next = S_EW_Y;
                S_EW_Y:  w_next = S_AR2;
                S_PED:   w_next = r_ret_ew ? S_EW_G : S_NS_G;
                default: w_next = r_ped ? S_PED : S_NS_G;
            endcase
        end
        w_adv       = (w_next != r_state);
        w_enter_ped = w_adv && (w_next == S_PED);

        unique case (w_next)
            S_NS_G, S_EW_G: w_load = LD_GREEN;
            S_NS_Y, S_EW_Y: w_load = LD_YELLOW;
            S_PED:          w_load = LD_PED;
            default:        w_load = LD_ALLRED;
        endcase

        w_timer_nxt = r_timer;
        if (w_adv)
            w_timer_nxt = w_load;
        else if (tick && (r_timer != '0))
            w_timer_nxt = r_timer - TIMER_WIDTH'(1);

        // entering the walk absorbs a same-edge request
        w_ped_nxt = r_ped;
        if (w_enter_ped)
            w_ped_nxt = 1'b0;
        else if (ped_req && (r_state != S_PED))
            w_ped_nxt = 1'b1;

        w_ret_nxt = r_ret_ew;
        if (w_enter_ped)
            w_ret_nxt = (r_state == S_AR1);
    end

    always_comb begin
        ns_lamp = L_RED;
        ew_lamp = L_RED;
        walk    = 1'b0;
        unique case (r_state)
            S_NS_G:  ns_lamp = L_GRN;
            S_NS_Y:  ns_lamp = L_YEL;
            S_EW_G:  ew_lamp = L_GRN;
            S_EW_Y:  ew_lamp = L_YEL;
            S_PED:   walk    = 1'b1;
            default: walk    = 1'b0;
        endcase
    end

    assign state      = r_state;
    assign timer      = r_timer;
    assign phase_done = r_phase_done;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: expected phase/timer/lamp
// sequences are planned from the phase table and compared cycle by cycle.
module tb_traffic_light_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] tm;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       wk;
        logic       pd;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       ew_car = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] ns_lamp;
    logic [2:0] ew_lamp;
    logic       walk;
    logic [2:0] state;
    logic [3:0] timer;
    logic       phase_done;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    exp_t e;
    exp_t o;

    traffic_light_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .ew_car     (ew_car),
        .ped_req    (ped_req),
        .ns_lamp    (ns_lamp),
        .ew_lamp    (ew_lamp),
        .walk       (walk),
        .state      (state),
        .timer      (timer),
        .phase_done (phase_done)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(int st, int tm, bit pd);
        exp_t r;
        r.st = 3'(st);
        r.tm = 4'(tm);
        r.ns = (st == 0) ? 3'b001 : (st == 1) ? 3'b010 : 3'b100;
        r.ew = (st == 3) ? 3'b001 : (st == 4) ? 3'b010 : 3'b100;
        r.wk = (st == 6);
        r.pd = pd;
        return r;
    endfunction

    function automatic int dur(int st);
        case (st)
            0, 3:    return 8;
            1, 4:    return 2;
            6:       return 4;
            default: return 1;
        endcase
    endfunction

    // queue one whole phase; each timer value lasts rep clocks
    function automatic void plan(int st, int rep);
        int n = dur(st);
        for (int k = 0; k < n; k++)
            for (int r = 0; r < rep; r++)
                sb.push_back(mk(st, n - 1 - k, (k == 0) && (r == 0)));
    endfunction

    function automatic exp_t obs();
        return {state, timer, ns_lamp, ew_lamp, walk, phase_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick = 1'b0;
        ped_req = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        tick = 1'b1;
        ew_car = 1'b1;
        ped_req = 1'b1;
        reset = 1'b1;
        sb.push_back(mk(5, 0, 1'b0));
        step();
        reset = 1'b0;
        ped_req = 1'b0;
        e = sb.pop_front();
        o = obs();
        n_cmp++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL reset: got %h want %h", o, e);
        end
    endtask

    task automatic test_cycle();
        do_reset();
        ew_car = 1'b1;
        tick = 1'b1;
        for (int p = 0; p < 2; p++) begin
            plan(0, 1); plan(1, 1); plan(2, 1);
            plan(3, 1); plan(4, 1); plan(5, 1);
        end
        for (int i = 0; sb.size() > 0; i++) begin
            step();
            e = sb.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL cycle[%0d]: got %h want %h", i, o, e);
            end
        end
    endtask

    task automatic test_extend();
        do_reset();
        ew_car = 1'b0;
        tick = 1'b1;
        plan(0, 1);
        for (int i = 0; i < 50; i++)
            sb.push_back(mk(0, 0, 1'b0));
        sb.push_back(mk(1, 1, 1'b1));
        for (int i = 0; sb.size() > 0; i++) begin
            ew_car = (sb.size() == 1);
            step();
            e = sb.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL extend[%0d]: got %h want %h", i, o, e);
            end
        end
        ew_car = 1'b1;
    endtask

    task automatic test_ped_pulse();
        do_reset();
        ew_car = 1'b1;
        tick = 1'b1;
        plan(0, 1); plan(1, 1); plan(2, 1); plan(3, 1);
        plan(4, 1); plan(5, 1); plan(6, 1); plan(0, 1);
        plan(1, 1); plan(2, 1); plan(3, 1);
        for (int i = 0; sb.size() > 0; i++) begin
            ped_req = (i == 13);
            step();
            e = sb.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL ped_pulse[%0d]: got %h want %h", i, o, e);
            end
        end
        ped_req = 1'b0;
    endtask

    task automatic test_slow_tick();
        do_reset();
        ew_car = 1'b1;
        plan(0, 5); plan(1, 5); plan(2, 5);
        plan(3, 5); plan(4, 5); plan(5, 5);
        plan(0, 5);
        for (int i = 0; sb.size() > 0; i++) begin
            tick = ((i % 5) == 0);
            step();
            e = sb.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL slow_tick[%0d]: got %h want %h", i, o, e);
            end
        end
        tick = 1'b1;
    endtask

    task automatic test_ped_held();
        do_reset();
        ew_car = 1'b1;
        tick = 1'b1;
        plan(0, 1); plan(1, 1); plan(2, 1); plan(6, 1);
        plan(3, 1); plan(4, 1); plan(5, 1); plan(0, 1);
        plan(1, 1); plan(2, 1); plan(6, 1); plan(3, 1);
        for (int i = 0; sb.size() > 0; i++) begin
            ped_req = (i <= 15) || (i == 28);
            step();
            e = sb.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL ped_held[%0d]: got %h want %h", i, o, e);
            end
        end
        ped_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ew_car = 1'b1;
        tick = 1'b1;
        plan(0, 1); plan(1, 1); plan(2, 1); plan(3, 1);
        sb.push_back(mk(4, 1, 1'b1));
        sb.push_back(mk(5, 0, 1'b0));
        sb.push_back(mk(0, 7, 1'b1));
        sb.push_back(mk(0, 6, 1'b0));
        for (int i = 0; sb.size() > 0; i++) begin
            reset = (sb.size() == 3);
            step();
            e = sb.pop_front();
            o = obs();
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL reset_mid[%0d]: got %h want %h", i, o, e);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        step();
        test_reset();
        test_cycle();
        test_extend();
        test_ped_pulse();
        test_slow_tick();
        test_ped_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
